// File: rtl/mmreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : mmreg_bank (with default obi_pkg types)
// Brief    : OBI register bank with RW control words, RO status words,
//            W1C event flags, an interrupt-enable mask and a registered irq.
// Revision : 1.0 - initial parametrised release
// ============================================================================

package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module mmreg_bank #(
    parameter obi_pkg::obi_cfg_t           OBI_CFG        = obi_pkg::ObiDefaultConfig,
    parameter type                         obi_req_t      = obi_pkg::obi_req_t,
    parameter type                         obi_rsp_t      = obi_pkg::obi_rsp_t,
    parameter int unsigned                 NUM_CTRL       = 4,
    parameter int unsigned                 NUM_STATUS     = 2,
    parameter logic [NUM_CTRL*32-1:0]      CTRL_RESET_VAL = '0,
    parameter int unsigned                 NUM_EVENTS     = 8
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  obi_req_t                                        obi_req_i,
    output obi_rsp_t                                        obi_rsp_o,
    output logic [NUM_CTRL*32-1:0]                          ctrl_o,
    input  logic [(NUM_STATUS > 0 ? NUM_STATUS : 1)*32-1:0] status_i,
    input  logic [NUM_EVENTS-1:0]                           event_i,
    output logic                                            irq_o
);

    localparam int unsigned c_aw         = $clog2(NUM_CTRL + NUM_STATUS + 2);
    localparam int unsigned c_id_w       = OBI_CFG.IdWidth;
    localparam int unsigned c_evt_idx    = NUM_CTRL + NUM_STATUS;
    localparam int unsigned c_irq_en_idx = NUM_CTRL + NUM_STATUS + 1;

    logic [31:0]           r_ctrl [NUM_CTRL];
    logic [NUM_EVENTS-1:0] r_evt;
    logic [NUM_EVENTS-1:0] r_irq_en;
    logic                  r_irq;
    logic                  r_rvalid;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic [c_id_w-1:0]     r_rid;

    logic [31:0]           w_idx;
    logic [31:0]           w_wdata;
    logic [31:0]           w_mask;
    logic                  w_req;
    logic                  w_we;
    logic                  w_is_ctrl;
    logic                  w_is_status;
    logic                  w_is_evt;
    logic                  w_is_irq_en;
    logic                  w_err;
    logic                  w_wr;
    logic [31:0]           w_rdata;
    logic [NUM_EVENTS-1:0] w_evt_clr;
    logic [NUM_EVENTS-1:0] w_evt_next;
    logic [NUM_EVENTS-1:0] w_irq_en_next;
    logic                  w_unused;

    // Address bits outside the word index are deliberately ignored.
    assign w_unused = ^{obi_req_i, status_i};

    assign w_req   = obi_req_i.req;
    assign w_we    = obi_req_i.a.we;
    assign w_wdata = obi_req_i.a.wdata;
    assign w_idx   = 32'(obi_req_i.a.addr[c_aw+1:2]);
    assign w_mask  = {{8{obi_req_i.a.be[3]}}, {8{obi_req_i.a.be[2]}},
                      {8{obi_req_i.a.be[1]}}, {8{obi_req_i.a.be[0]}}};

    assign w_is_ctrl   = (w_idx < NUM_CTRL);
    assign w_is_status = (w_idx >= NUM_CTRL) && (w_idx < c_evt_idx);
    assign w_is_evt    = (w_idx == c_evt_idx);
    assign w_is_irq_en = (w_idx == c_irq_en_idx);

    assign w_err = ~(w_is_ctrl | w_is_status | w_is_evt | w_is_irq_en) | (w_we & w_is_status);
    assign w_wr  = w_req & w_we & ~w_err;

    always_comb begin
        w_rdata = '0;
        if (!w_we) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (w_idx == 32'(k)) w_rdata = r_ctrl[k];
            end
            for (int k = 0; k < NUM_STATUS; k++) begin
                if (w_idx == NUM_CTRL + 32'(k)) w_rdata = status_i[32*k +: 32];
            end
            if (w_is_evt)    w_rdata = 32'(r_evt);
            if (w_is_irq_en) w_rdata = 32'(r_irq_en);
        end
    end

    // A new event pulse overrides a simultaneous W1C clear of the same bit.
    assign w_evt_clr  = (w_wr && w_is_evt) ?
                        (w_wdata[NUM_EVENTS-1:0] & w_mask[NUM_EVENTS-1:0]) : '0;
    assign w_evt_next = (r_evt & ~w_evt_clr) | event_i;

    assign w_irq_en_next = (w_wr && w_is_irq_en) ?
                           ((r_irq_en & ~w_mask[NUM_EVENTS-1:0]) |
                            (w_wdata[NUM_EVENTS-1:0] & w_mask[NUM_EVENTS-1:0])) : r_irq_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                r_ctrl[k] <= CTRL_RESET_VAL[32*k +: 32];
            end
            r_evt    <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
        end else begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (w_wr && w_idx == 32'(k)) begin
                    r_ctrl[k] <= (r_ctrl[k] & ~w_mask) | (w_wdata & w_mask);
                end
            end
            r_evt    <= w_evt_next;
            r_irq_en <= w_irq_en_next;
            r_irq    <= |(w_evt_next & w_irq_en_next);
            r_rvalid <= w_req;
            if (w_req) begin
                r_err   <= w_err;
                r_rdata <= w_rdata;
                r_rid   <= obi_req_i.a.aid;
            end
        end
    end

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
        assign ctrl_o[32*k +: 32] = r_ctrl[k];
    end

    assign irq_o = r_irq;

    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = obi_req_i.req;
        obi_rsp_o.rvalid   = r_rvalid;
        obi_rsp_o.r.rdata  = r_rdata;
        obi_rsp_o.r.rid    = r_rid;
        obi_rsp_o.r.err    = r_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_mmreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmreg_bank
// Brief    : Self-checking bench: directed and random OBI traffic against a
//            register-map model of the bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmreg_bank;
    localparam int NC = 4;
    localparam int NS = 3;
    localparam int NE = 8;
    localparam int AW = $clog2(NC + NS + 2);
    localparam int E  = NC + NS;
    localparam logic [NC*32-1:0] RST_VAL = {96'h0, 32'hA5A5_0001};

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    obi_pkg::obi_req_t   req;
    obi_pkg::obi_rsp_t   rsp;
    logic [NC*32-1:0]    ctrl;
    logic [NS*32-1:0]    status;
    logic [NE-1:0]       evt_in;
    logic                irq;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [31:0] m_ctrl [NC];
    logic [NE-1:0] m_evt, m_en;
    logic        m_rvalid, m_irq, m_err;
    logic [31:0] m_rdata;
    logic [3:0]  m_rid;

    always #5 clk = ~clk;

    mmreg_bank #(
        .OBI_CFG        (obi_pkg::ObiDefaultConfig),
        .obi_req_t      (obi_pkg::obi_req_t),
        .obi_rsp_t      (obi_pkg::obi_rsp_t),
        .NUM_CTRL       (NC),
        .NUM_STATUS     (NS),
        .CTRL_RESET_VAL (RST_VAL),
        .NUM_EVENTS     (NE)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .ctrl_o    (ctrl),
        .status_i  (status),
        .event_i   (evt_in),
        .irq_o     (irq)
    );

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-map model: decode the word, apply read/write rules, then events.
    always @(posedge clk) begin
        automatic int          idx;
        automatic logic [31:0] bm, rd;
        automatic logic        e;
        automatic logic [NE-1:0] nevt, nen;
        if (rst) begin
            for (int k = 0; k < NC; k++) m_ctrl[k] <= RST_VAL[32*k +: 32];
            m_evt <= '0; m_en <= '0; m_irq <= 1'b0;
            m_rvalid <= 1'b0; m_err <= 1'b0; m_rdata <= '0; m_rid <= '0;
        end else begin
            nevt = m_evt;
            nen  = m_en;
            if (req.req) begin
                idx = int'((req.a.addr >> 2) & ((32'd1 << AW) - 1));
                bm  = {{8{req.a.be[3]}}, {8{req.a.be[2]}}, {8{req.a.be[1]}}, {8{req.a.be[0]}}};
                rd  = '0;
                e   = 1'b0;
                if (idx < NC) begin
                    if (!req.a.we) rd = m_ctrl[idx];
                    else m_ctrl[idx] <= (m_ctrl[idx] & ~bm) | (req.a.wdata & bm);
                end else if (idx < E) begin
                    if (!req.a.we) rd = status[32*(idx-NC) +: 32];
                    else e = 1'b1;
                end else if (idx == E) begin
                    if (!req.a.we) rd = 32'(m_evt);
                    else nevt = m_evt & ~NE'(req.a.wdata & bm);
                end else if (idx == E + 1) begin
                    if (!req.a.we) rd = 32'(m_en);
                    else nen = NE'((32'(m_en) & ~bm) | (req.a.wdata & bm));
                end else begin
                    e = 1'b1;
                end
                m_rdata <= rd;
                m_err   <= e;
                m_rid   <= req.a.aid;
            end
            nevt = nevt | evt_in;
            m_evt    <= nevt;
            m_en     <= nen;
            m_irq    <= |(nevt & nen);
            m_rvalid <= req.req;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("gnt", rsp.gnt, req.req);
            check("rvalid", rsp.rvalid, m_rvalid);
            check("irq", irq, m_irq);
            check("ctrl_o", ctrl, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            if (m_rvalid) begin
                check("rid", rsp.r.rid, m_rid);
                check("rdata", rsp.r.rdata, m_rdata);
                check("err", rsp.r.err, m_err);
            end
        end
    end

    task automatic drive(bit we, int idx, logic [31:0] wd, logic [3:0] be, logic [3:0] aid);
        req.req     = 1'b1;
        req.a.we    = we;
        req.a.addr  = (32'($urandom) << (AW + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
        req.a.wdata = wd;
        req.a.be    = be;
        req.a.aid   = aid;
        @(negedge clk); #1;
    endtask

    task automatic idle(int n);
        req.req = 1'b0;
        evt_in  = '0;
        repeat (n) begin @(negedge clk); #1; end
    endtask

    initial begin
        logic [31:0] exp_rd [5];
        logic [31:0] v;
        exp_rd = '{32'hA5A5_0001, 32'h0, 32'h0, 32'h0, 32'h0};
        req = '0; evt_in = '0; status = '0;
        repeat (2) @(negedge clk);
        #1;
        armed = 1'b1;
        check("rst_rvalid", rsp.rvalid, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_ctrl0", ctrl[31:0], 32'hA5A5_0001);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, (i < 4) ? i : E + 1, 32'h0, 4'hF, 4'(i + 3));
            check("rd_reset_val", rsp.r.rdata, exp_rd[i]);
            check("rd_rid", rsp.r.rid, 4'(i + 3));
            check("rd_rvalid", rsp.rvalid, 1'b1);
            check("rd_err", rsp.r.err, 1'b0);
        end
        idle(1);

        drive(1'b1, 1, 32'hFFFF_FFFF, 4'hF, 4'h1);
        drive(1'b1, 1, 32'h1234_5678, 4'b0101, 4'h2);
        check("ctrl1_out", ctrl[63:32], 32'hFF34_FF78);
        check("wr_rdata_zero", rsp.r.rdata, 32'h0);
        drive(1'b0, 1, 32'h0, 4'hF, 4'h3);
        check("ctrl1_rd", rsp.r.rdata, 32'hFF34_FF78);
        idle(1);

        status = {64'h0, 32'hDEAD_BEEF};
        drive(1'b0, 4, 32'h0, 4'hF, 4'h4);
        check("status_rd", rsp.r.rdata, 32'hDEAD_BEEF);
        drive(1'b1, 4, 32'h0, 4'hF, 4'h5);
        check("status_wr_err", rsp.r.err, 1'b1);
        drive(1'b0, 4, 32'h0, 4'hF, 4'h6);
        check("status_rd_again", rsp.r.rdata, 32'hDEAD_BEEF);
        drive(1'b0, 9, 32'h0, 4'hF, 4'h7);
        check("unmapped_err", rsp.r.err, 1'b1);
        check("unmapped_rdata", rsp.r.rdata, 32'h0);
        idle(1);

        evt_in = 8'h05;
        @(negedge clk); #1;
        evt_in = '0;
        drive(1'b1, E + 1, 32'h4, 4'hF, 4'h8);
        check("irq_raise", irq, 1'b1);
        drive(1'b1, E, 32'h4, 4'hF, 4'h9);
        check("irq_clear", irq, 1'b0);
        drive(1'b0, E, 32'h0, 4'hF, 4'hA);
        check("evt_rd", rsp.r.rdata, 32'h1);
        drive(1'b1, E, 32'h1, 4'hF, 4'hB);
        drive(1'b0, E, 32'h0, 4'hF, 4'hC);
        check("evt_cleared", rsp.r.rdata, 32'h0);
        evt_in = 8'h01;
        drive(1'b1, E, 32'h1, 4'hF, 4'hD);
        evt_in = '0;
        drive(1'b0, E, 32'h0, 4'hF, 4'hE);
        check("evt_set_wins", rsp.r.rdata, 32'h1);
        idle(1);

        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 49) == 0);
            req.req     = $urandom_range(0, 3) != 0;
            req.a.we    = $urandom_range(0, 1) == 1;
            req.a.addr  = $urandom;
            req.a.wdata = $urandom;
            req.a.be    = 4'($urandom);
            req.a.aid   = 4'($urandom);
            status      = {$urandom, $urandom, $urandom};
            evt_in      = NE'($urandom & $urandom & $urandom);
            @(negedge clk); #1;
        end
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 2; i++) begin
            v = $urandom;
            drive(1'b1, 2, v, 4'hF, 4'(2 * i));
            drive(1'b0, 2, 32'h0, 4'hF, 4'(2 * i + 1));
            check("b2b_rd", rsp.r.rdata, v);
        end
        rst = 1'b1;
        drive(1'b1, 2, 32'hCAFE_F00D, 4'hF, 4'hF);
        rst = 1'b0;
        req.req = 1'b0;
        check("rst_no_rvalid", rsp.rvalid, 1'b0);
        check("rst_ctrl2", ctrl[95:64], 32'h0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
